decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined instruction-decode stage for the MIPS-style core. Sits between fetch and execute as the IF/ID register plus field extraction.
- Splits a registered instruction word into rs/rt/rd/shamt/opcode/funct fields. Produces an immediate extended in one of four modes.
- Valid/ready handshakes on both sides, a flush input, load-use hazard masking, and a saturating stall counter.

Parameters:
- XLEN, 32, instruction and immediate output width
- RADDR_W, 5, register-address field width
- IMM_W, 16, raw immediate field width (in_is[IMM_W-1:0])
- CNT_W, 16, stall counter width

Ports:
- in_clk  input  1  clock, all state updates on rising edge
- in_rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  upstream instruction valid
- out_ready  output  1  stage can accept an instruction this cycle
- in_is  input  XLEN  instruction word
- in_pc  input  XLEN  PC of in_is
- in_ext_mode  input  2  00 zero-ext, 01 sign-ext, 10 upper (imm<<16), 11 sign-ext then <<2
- in_flush  input  1  discard the held instruction (branch or jump taken)
- in_ready  input  1  downstream (EX) ready
- in_ex_memread  input  1  instruction currently in EX is a load
- in_ex_rt  input  RADDR_W  destination of that load
- out_valid  output  1  decoded instruction presented to EX
- out_rs  output  RADDR_W  in_is[25:21]
- out_rt  output  RADDR_W  in_is[20:16]
- out_rd  output  RADDR_W  in_is[15:11]
- out_shamt  output  5  in_is[10:6]
- out_opcode  output  6  in_is[31:26]
- out_funct  output  6  in_is[5:0]
- out_im  output  XLEN  extended immediate
- out_pc  output  XLEN  registered PC
- out_stall  output  1  hazard mask active this cycle
- out_stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (in_rst_n=0 at edge): hold register empty (valid bit 0); all field registers, out_im, out_pc and out_stall_cnt cleared to 0. out_valid=0, out_stall=0 while reset is applied.
- Single-entry hold register. Fields, immediate and PC are captured at the edge when in_valid && out_ready. Latency is 1 cycle from acceptance to out_valid.
- The immediate is extended at capture time according to in_ext_mode sampled with the instruction:
  - 00: zero-fill.
  - 01: replicate bit IMM_W-1.
  - 10: imm in [XLEN-1:XLEN-IMM_W], lower bits zero.
  - 11: sign-extend, then shift left 2, discarding the top bits.
- hazard = held_valid && in_ex_memread && in_ex_rt!=0 && (in_ex_rt==out_rs || in_ex_rt==out_rt). This is combinational on the held entry.
- Output and ready logic:
  - out_valid = held_valid && !hazard.
  - out_stall = hazard.
  - out_ready = !held_valid || (in_ready && !hazard).
- Transfer to EX occurs when out_valid && in_ready. If no new acceptance happens in the same cycle, the entry empties. A simultaneous accept and transfer replaces the entry (back-to-back throughput of 1 per cycle).
- During hazard the entry and all fields are held unchanged and no upstream acceptance occurs. EX then receives a bubble (out_valid=0).
- in_flush: at the edge, held_valid is cleared and the incoming instruction is not accepted, even if in_valid && out_ready. Flush overrides hazard and any simultaneous accept. Field registers may keep stale values, but out_valid must be 0 the cycle after.
- out_stall_cnt increments by 1 at each edge where out_stall=1, saturates at all-ones, and is cleared only by reset.
- Output fields are registered; only out_valid, out_stall and out_ready are combinational.
- Reset mid-hazard or mid-transfer: the entry is dropped and the counter is zeroed.

Decomposition:
- Shared package decode_pkg: ext-mode constants (EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_BR) and field bit-position constants (OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SH_HI/LO, FN_HI/LO).
- One natural sub-module: imm_extender (combinational, parametrised IMM_W/XLEN, 4-mode). It replaces the old fixed 2-mode extender.

Test Plan:
- Reset then in_is=0x012A4020 (add $8,$9,$10) accepted with in_ready=1 -> next cycle out_valid=1, out_rs=9, out_rt=10, out_rd=8, out_funct=0x20, out_opcode=0.
- Immediate 0x8004 with ext modes 00/01/10/11 -> out_im = 0x00008004 / 0xFFFF8004 / 0x80040000 / 0xFFFE0010.
- Held rs=9; in_ex_memread=1, in_ex_rt=9 for 1 cycle -> out_valid=0, out_stall=1, out_ready=0, fields unchanged, out_stall_cnt 0->1. Next cycle with memread=0 -> out_valid=1.
- Same case with in_ex_rt=0 -> no stall, out_valid=1.
- in_ready=0 with entry held and in_valid=1 -> out_ready=0 and entry unchanged. Then in_flush=1 -> next cycle out_valid=0 and the new instruction was not captured.
- Continuous in_valid/in_ready for 8 instructions -> 8 consecutive out_valid cycles in order with matching out_pc. Hold the hazard for 2^CNT_W+3 cycles (CNT_W overridden to 4) -> out_stall_cnt saturates at 15.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants for the instruction decode stage
package decode_pkg;

    // Immediate extension modes, sampled together with the instruction
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] EXT_BR    = 2'b11;

    // MIPS instruction field bit positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int SH_HI = 10;
    localparam int SH_LO = 6;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

endpackage

// File: rtl/imm_extender.sv
// rtl/imm_extender.sv - four-mode immediate extender (zero, sign, upper, branch)
module imm_extender
    import decode_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int XLEN  = 32
) (
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       mode,
    output logic [XLEN-1:0]  imm_ext
);

    logic [XLEN-1:0] sext;

    // Select the extension flavour; branch mode reuses the sign-extended value
    always_comb begin
        sext    = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
        imm_ext = '0;
        case (mode)
            EXT_ZERO:  imm_ext = {{(XLEN-IMM_W){1'b0}}, imm};
            EXT_SIGN:  imm_ext = sext;
            EXT_UPPER: imm_ext = {imm, {(XLEN-IMM_W){1'b0}}};
            EXT_BR:    imm_ext = {sext[XLEN-3:0], 2'b00};
            default:   imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID hold register with field decode, load-use masking and stall counter
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_valid,
    output logic               out_ready,
    input  logic [XLEN-1:0]    in_is,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [1:0]         in_ext_mode,
    input  logic               in_flush,
    input  logic               in_ready,
    input  logic               in_ex_memread,
    input  logic [RADDR_W-1:0] in_ex_rt,
    output logic               out_valid,
    output logic [RADDR_W-1:0] out_rs,
    output logic [RADDR_W-1:0] out_rt,
    output logic [RADDR_W-1:0] out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_opcode,
    output logic [5:0]         out_funct,
    output logic [XLEN-1:0]    out_im,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_stall,
    output logic [CNT_W-1:0]   out_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               held_valid_q, held_valid_d;
    logic [RADDR_W-1:0] rs_q, rs_d;
    logic [RADDR_W-1:0] rt_q, rt_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [5:0]         opcode_q, opcode_d;
    logic [5:0]         funct_q, funct_d;
    logic [XLEN-1:0]    im_q, im_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               hazard;
    logic               accept;
    logic               transfer;
    logic [XLEN-1:0]    imm_ext;

    imm_extender #(
        .IMM_W (IMM_W),
        .XLEN  (XLEN)
    ) u_imm_extender (
        .imm     (in_is[IMM_W-1:0]),
        .mode    (in_ext_mode),
        .imm_ext (imm_ext)
    );

    // Load-use hazard on the held entry gates both the output and upstream acceptance
    always_comb begin
        hazard    = held_valid_q && in_ex_memread && (in_ex_rt != '0) &&
                    ((in_ex_rt == rs_q) || (in_ex_rt == rt_q));
        out_valid = held_valid_q && !hazard;
        out_stall = hazard;
        out_ready = !held_valid_q || (in_ready && !hazard);
        accept    = in_valid && out_ready && !in_flush;
        transfer  = out_valid && in_ready;
    end

    // Next-state: flush wins, then capture, then drain; counter saturates on stall cycles
    always_comb begin
        held_valid_d = held_valid_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        shamt_d      = shamt_q;
        opcode_d     = opcode_q;
        funct_d      = funct_q;
        im_d         = im_q;
        pc_d         = pc_q;
        stall_cnt_d  = stall_cnt_q;

        if (in_flush) begin
            held_valid_d = 1'b0;
        end else if (accept) begin
            held_valid_d = 1'b1;
            rs_d         = RADDR_W'(in_is[RS_HI:RS_LO]);
            rt_d         = RADDR_W'(in_is[RT_HI:RT_LO]);
            rd_d         = RADDR_W'(in_is[RD_HI:RD_LO]);
            shamt_d      = in_is[SH_HI:SH_LO];
            opcode_d     = in_is[OP_HI:OP_LO];
            funct_d      = in_is[FN_HI:FN_LO];
            im_d         = imm_ext;
            pc_d         = in_pc;
        end else if (transfer) begin
            held_valid_d = 1'b0;
        end

        if (hazard && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            held_valid_q <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            shamt_q      <= '0;
            opcode_q     <= '0;
            funct_q      <= '0;
            im_q         <= '0;
            pc_q         <= '0;
            stall_cnt_q  <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            shamt_q      <= shamt_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            im_q         <= im_d;
            pc_q         <= pc_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Registered fields drive the EX-side outputs directly
    always_comb begin
        out_rs        = rs_q;
        out_rt        = rt_q;
        out_rd        = rd_q;
        out_shamt     = shamt_q;
        out_opcode    = opcode_q;
        out_funct     = funct_q;
        out_im        = im_q;
        out_pc        = pc_q;
        out_stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage
module tb_decode_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_flush, in_ready, ex_memread;
    logic [31:0] in_is, in_pc;
    logic [1:0]  ext_mode;
    logic [4:0]  ex_rt;
    logic        out_ready, out_valid, out_stall;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]  out_opcode, out_funct;
    logic [31:0] out_im, out_pc;
    logic [CNT_W-1:0] out_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_xfers = 0;
    bit chk_en = 0;

    // reference state: what the stage is holding, in plain terms
    bit          m_valid;
    logic [31:0] m_is, m_pc, m_im;
    int          m_cnt;

    always #5 clk = ~clk;

    decode_stage #(.CNT_W(CNT_W)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
        .in_is(in_is), .in_pc(in_pc), .in_ext_mode(ext_mode), .in_flush(in_flush),
        .in_ready(in_ready), .in_ex_memread(ex_memread), .in_ex_rt(ex_rt),
        .out_valid(out_valid), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_opcode(out_opcode), .out_funct(out_funct),
        .out_im(out_im), .out_pc(out_pc), .out_stall(out_stall), .out_stall_cnt(out_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] is, input logic [1:0] mode);
        longint unsigned imm, s;
        imm = is & 32'hFFFF;
        s   = (imm >= 32768) ? imm + 64'hFFFF0000 : imm;
        case (mode)
            2'd0:    return 32'(imm);
            2'd1:    return 32'(s);
            2'd2:    return 32'(imm * 65536);
            default: return 32'((s * 4) % 64'h1_0000_0000);
        endcase
    endfunction

    // Drive one cycle of inputs, check against the model, then advance both across the edge
    task automatic step(input bit rn, input bit v, input logic [31:0] is, input logic [31:0] pc,
                        input logic [1:0] mode, input bit fl, input bit rdy, input bit mr,
                        input logic [4:0] xrt);
        bit haz, ev, er, acc, xfer;
        int rs, rt;
        rst_n = rn; in_valid = v; in_is = is; in_pc = pc; ext_mode = mode;
        in_flush = fl; in_ready = rdy; ex_memread = mr; ex_rt = xrt;
        #1;
        rs  = (m_is >> 21) % 32;
        rt  = (m_is >> 16) % 32;
        haz = m_valid && mr && (xrt != 0) && ((xrt == rs) || (xrt == rt));
        ev  = m_valid && !haz;
        er  = !m_valid || (rdy && !haz);
        if (out_valid === 1'b1 && rdy) dut_xfers++;
        if (chk_en) begin
            chk("valid", {31'd0, out_valid}, {31'd0, ev});
            chk("ready", {31'd0, out_ready}, {31'd0, er});
            chk("stall", {31'd0, out_stall}, {31'd0, haz});
            chk("rs", {27'd0, out_rs}, 32'(rs));
            chk("rt", {27'd0, out_rt}, 32'(rt));
            chk("rd", {27'd0, out_rd}, (m_is >> 11) % 32);
            chk("shamt", {27'd0, out_shamt}, (m_is >> 6) % 32);
            chk("opcode", {26'd0, out_opcode}, m_is / 32'h0400_0000);
            chk("funct", {26'd0, out_funct}, m_is % 64);
            chk("im", out_im, m_im);
            chk("pc", out_pc, m_pc);
            chk("cnt", 32'(out_stall_cnt), 32'(m_cnt));
        end
        acc  = v && er && !fl;
        xfer = ev && rdy;
        @(posedge clk);
        if (!rn) begin
            m_valid = 0; m_is = 0; m_pc = 0; m_im = 0; m_cnt = 0;
        end else begin
            if (haz && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (fl) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_is = is; m_pc = pc; m_im = ref_imm(is, mode);
            end else if (xfer) m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1, 0, 32'h0, 32'h0, 2'd0, 0, rdy, 0, 5'd0);
    endtask

    initial begin
        logic [31:0] exp_im [4];
        logic [31:0] rs_is, rp, rpc;
        logic [4:0]  rxrt;
        int sel;
        exp_im = '{32'h0000_8004, 32'hFFFF_8004, 32'h8004_0000, 32'hFFFE_0010};
        m_valid = 0; m_is = 0; m_pc = 0; m_im = 0; m_cnt = 0;
        @(negedge clk);
        step(0, 0, 32'h0, 32'h0, 2'd0, 0, 0, 0, 5'd0);
        chk_en = 1;
        step(0, 1, 32'hFFFF_FFFF, 32'h4, 2'd1, 0, 1, 1, 5'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", 32'(out_stall_cnt), 32'd0);

        // add $8,$9,$10
        step(1, 1, 32'h012A_4020, 32'h100, 2'd0, 0, 1, 0, 5'd0);
        chk("add_rs", {27'd0, out_rs}, 32'd9);
        chk("add_rt", {27'd0, out_rt}, 32'd10);
        chk("add_rd", {27'd0, out_rd}, 32'd8);
        chk("add_funct", {26'd0, out_funct}, 32'h20);
        idle(1);

        // immediate modes
        for (int m = 0; m < 4; m++) begin
            step(1, 1, 32'h2128_8004, 32'h200 + 32'(m), 2'(m), 0, 1, 0, 5'd0);
            chk("imm_mode", out_im, exp_im[m]);
        end
        idle(1);

        // load-use hazard on rs=9, then clear; then ex_rt=0 gives no stall
        step(1, 1, 32'h012A_4020, 32'h300, 2'd0, 0, 1, 0, 5'd0);
        step(1, 0, 32'h0, 32'h0, 2'd0, 0, 1, 1, 5'd9);
        chk("haz_cnt", 32'(out_stall_cnt), 32'd1);
        chk("haz_pc", out_pc, 32'h300);
        step(1, 0, 32'h0, 32'h0, 2'd0, 0, 0, 1, 5'd0);
        idle(1);

        // backpressure then flush
        step(1, 1, 32'h012A_4020, 32'h400, 2'd0, 0, 0, 0, 5'd0);
        step(1, 1, 32'hDEAD_BEEF, 32'h404, 2'd1, 0, 0, 0, 5'd0);
        step(1, 1, 32'hDEAD_BEEF, 32'h408, 2'd1, 1, 0, 0, 5'd0);
        chk("flush_pc", out_pc, 32'h400);
        step(1, 0, 32'h0, 32'h0, 2'd0, 0, 1, 0, 5'd0);

        // back-to-back burst of 8
        dut_xfers = 0;
        for (int i = 0; i < 8; i++)
            step(1, 1, $urandom, 32'h1000 + 32'(4 * i), 2'($urandom_range(0, 3)), 0, 1, 0, 5'd0);
        idle(1);
        chk("burst_xfers", 32'(dut_xfers), 32'd8);

        // saturation of the stall counter
        step(1, 1, 32'h012A_4020, 32'h500, 2'd0, 0, 1, 0, 5'd0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            step(1, 0, 32'h0, 32'h0, 2'd0, 0, 1, 1, 5'd10);
        chk("sat_cnt", 32'(out_stall_cnt), 32'd15);
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rs_is = $urandom;
            rpc   = $urandom;
            sel   = $urandom_range(0, 3);
            rp    = m_is;
            case (sel)
                0: rxrt = 5'd0;
                1: rxrt = 5'((rp >> 21) % 32);
                2: rxrt = 5'((rp >> 16) % 32);
                default: rxrt = 5'($urandom);
            endcase
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, rs_is, rpc,
                 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rxrt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
